// File: rtl/dot_product_scheduler.sv
// Sequences a length-N dot product: streams operand reads, pipelines multiply, accumulates
// with wrap and sticky signed overflow, then publishes the result with a one-cycle pulse.
module dot_product_scheduler #(
  parameter int unsigned IN_M_WIDTH      = 10,
  parameter int unsigned ACC_WIDTH       = 24,
  parameter int unsigned LEN_WIDTH       = 8,
  parameter int unsigned MEM_LAT         = 1,
  parameter int unsigned INPUT_REG_DEPTH = 1,
  parameter int unsigned MULT_PIPE_DEPTH = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         len,
  output logic                         rdEn,
  output logic [LEN_WIDTH-1:0]         rdAddr,
  input  logic signed [IN_M_WIDTH-1:0] A,
  input  logic signed [IN_M_WIDTH-1:0] B,
  output logic                         busy,
  output logic                         outReady,
  output logic signed [ACC_WIDTH-1:0]  RES,
  output logic                         ovf
);

  localparam int unsigned PW        = 2 * IN_M_WIDTH;
  localparam int unsigned OW        = PW + 1;
  localparam int unsigned DRAIN_CYC = MEM_LAT + INPUT_REG_DEPTH + MULT_PIPE_DEPTH;
  localparam int unsigned CW        = $clog2(DRAIN_CYC + 1) + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                       state_q;
  logic                         rd_en_q, out_ready_q, ovf_q;
  logic [LEN_WIDTH-1:0]         len_q, addr_q;
  logic [CW-1:0]                drain_cnt_q;
  logic signed [ACC_WIDTH-1:0]  acc_q, res_q;

  // Registered pulses stay frozen while disabled and show up in the next enabled cycle.
  assign rdEn     = rd_en_q & enable;
  assign outReady = out_ready_q & enable;
  assign rdAddr   = addr_q;
  assign busy     = (state_q != StIdle);
  assign RES      = res_q;
  assign ovf      = ovf_q;

  logic mem_vld;
  if (MEM_LAT > 0) begin : g_mem
    logic [MEM_LAT-1:0] vld_sr;
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_sr <= '0;
      end else if (enable) begin
        vld_sr[0] <= rd_en_q;
        for (int i = 1; i < MEM_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      end
    end
    assign mem_vld = vld_sr[MEM_LAT-1];
  end else begin : g_no_mem
    assign mem_vld = rd_en_q;
  end

  logic [OW-1:0] opnd_in, opnd_out;
  assign opnd_in = {mem_vld, A, B};
  if (INPUT_REG_DEPTH > 0) begin : g_opnd
    logic [OW-1:0] sr [INPUT_REG_DEPTH];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < INPUT_REG_DEPTH; i++) sr[i] <= '0;
      end else if (enable) begin
        sr[0] <= opnd_in;
        for (int i = 1; i < INPUT_REG_DEPTH; i++) sr[i] <= sr[i-1];
      end
    end
    assign opnd_out = sr[INPUT_REG_DEPTH-1];
  end else begin : g_no_opnd
    assign opnd_out = opnd_in;
  end

  logic                         op_vld;
  logic signed [IN_M_WIDTH-1:0] op_a, op_b;
  logic signed [PW-1:0]         prod;
  assign op_vld = opnd_out[OW-1];
  assign op_a   = opnd_out[PW-1:IN_M_WIDTH];
  assign op_b   = opnd_out[IN_M_WIDTH-1:0];
  assign prod   = PW'(op_a) * PW'(op_b);

  logic [OW-1:0] prod_in, prod_out;
  assign prod_in = {op_vld, prod};
  if (MULT_PIPE_DEPTH > 0) begin : g_prod
    logic [OW-1:0] sr [MULT_PIPE_DEPTH];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < MULT_PIPE_DEPTH; i++) sr[i] <= '0;
      end else if (enable) begin
        sr[0] <= prod_in;
        for (int i = 1; i < MULT_PIPE_DEPTH; i++) sr[i] <= sr[i-1];
      end
    end
    assign prod_out = sr[MULT_PIPE_DEPTH-1];
  end else begin : g_no_prod
    assign prod_out = prod_in;
  end

  logic                        p_vld, add_ovf;
  logic signed [PW-1:0]        p_val;
  logic signed [ACC_WIDTH-1:0] prod_ext, sum;
  assign p_vld    = prod_out[OW-1];
  assign p_val    = prod_out[PW-1:0];
  assign prod_ext = ACC_WIDTH'(p_val);
  assign sum      = acc_q + prod_ext;
  // Same-sign operands producing an opposite-sign sum means the signed add wrapped.
  assign add_ovf  = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                    (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_en_q     <= 1'b0;
      out_ready_q <= 1'b0;
      ovf_q       <= 1'b0;
      len_q       <= '0;
      addr_q      <= '0;
      drain_cnt_q <= '0;
      acc_q       <= '0;
      res_q       <= '0;
    end else if (enable) begin
      out_ready_q <= 1'b0;
      if (p_vld) begin
        acc_q <= sum;
        if (add_ovf) ovf_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q  <= len;
            addr_q <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            if (len == '0) begin
              state_q <= StDone;
            end else begin
              state_q <= StFetch;
              rd_en_q <= 1'b1;
            end
          end
        end
        StFetch: begin
          if (addr_q == len_q - LEN_WIDTH'(1)) begin
            rd_en_q     <= 1'b0;
            drain_cnt_q <= '0;
            state_q     <= (DRAIN_CYC == 0) ? StDone : StDrain;
          end else begin
            addr_q <= addr_q + LEN_WIDTH'(1);
          end
        end
        StDrain: begin
          if (drain_cnt_q == CW'(DRAIN_CYC - 1)) begin
            state_q <= StDone;
          end else begin
            drain_cnt_q <= drain_cnt_q + CW'(1);
          end
        end
        StDone: begin
          res_q       <= acc_q;
          out_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Directed bench for dot_product_scheduler: a scoreboard of expected results per job, checked
// against outReady, along with read sequencing, latency, enable gating and mid-job reset.
module tb_dot_product_scheduler;

  localparam int MEM_LAT = 1;
  localparam int IRD     = 1;
  localparam int MPD     = 1;
  localparam int D       = MEM_LAT + IRD + MPD;

  logic clk, rst, en, start0, start1;
  logic [7:0] len;
  logic rdEn0, rdEn1, busy0, busy1, outReady0, outReady1, ovf0, ovf1;
  logic [7:0] rdAddr0, rdAddr1;
  logic signed [9:0] A0, B0, A1, B1;
  logic signed [23:0] RES0;
  logic signed [19:0] RES1;

  int checks = 0;
  int errors = 0;
  bit sel;
  int mem_a [256];
  int mem_b [256];

  typedef struct {
    logic signed [63:0] res;
    logic               ovf;
    int                 lat;
  } exp_t;
  exp_t sb[$];

  dot_product_scheduler #(
    .IN_M_WIDTH(10), .ACC_WIDTH(24), .LEN_WIDTH(8),
    .MEM_LAT(MEM_LAT), .INPUT_REG_DEPTH(IRD), .MULT_PIPE_DEPTH(MPD)
  ) u_dut (
    .clk(clk), .reset(rst), .enable(en), .start(start0), .len(len),
    .rdEn(rdEn0), .rdAddr(rdAddr0), .A(A0), .B(B0),
    .busy(busy0), .outReady(outReady0), .RES(RES0), .ovf(ovf0)
  );

  dot_product_scheduler #(
    .IN_M_WIDTH(10), .ACC_WIDTH(20), .LEN_WIDTH(8),
    .MEM_LAT(MEM_LAT), .INPUT_REG_DEPTH(IRD), .MULT_PIPE_DEPTH(MPD)
  ) u_dut20 (
    .clk(clk), .reset(rst), .enable(en), .start(start1), .len(len),
    .rdEn(rdEn1), .rdAddr(rdAddr1), .A(A1), .B(B1),
    .busy(busy1), .outReady(outReady1), .RES(RES1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand memory with one enabled cycle of read latency.
  initial begin
    A0 = '0; B0 = '0; A1 = '0; B1 = '0;
  end
  always @(posedge clk) begin
    if (rdEn0) begin
      A0 <= 10'(mem_a[rdAddr0]);
      B0 <= 10'(mem_b[rdAddr0]);
    end
    if (rdEn1) begin
      A1 <= 10'(mem_a[rdAddr1]);
      B1 <= 10'(mem_b[rdAddr1]);
    end
  end

  logic rd_en_s, out_rdy_s, busy_s, ovf_s;
  logic [7:0] rd_addr_s;
  logic signed [63:0] res_s;
  always_comb begin
    rd_en_s = rdEn0; out_rdy_s = outReady0; busy_s = busy0; ovf_s = ovf0;
    rd_addr_s = rdAddr0; res_s = 64'(RES0);
    if (sel) begin
      rd_en_s = rdEn1; out_rdy_s = outReady1; busy_s = busy1; ovf_s = ovf1;
      rd_addr_s = rdAddr1; res_s = 64'(RES1);
    end
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  task automatic drive_start(input bit v);
    start0 = v && !sel;
    start1 = v && sel;
  endtask

  // One job: push the model result, then step cycles until outReady (bounded).
  task automatic run_job(input int n, input bit toggle_en, input bit hold, input bit prestarted,
                         input string tag);
    exp_t   e;
    int     w, ecyc, rd_cnt;
    longint acc, p, s;
    bit     ov, got;
    w = sel ? 20 : 24;
    acc = 0;
    ov = 0;
    for (int i = 0; i < n; i++) begin
      p = longint'(mem_a[i]) * longint'(mem_b[i]);
      s = sx(acc + p, w);
      if (((acc < 0) == (p < 0)) && ((s < 0) != (acc < 0))) ov = 1;
      acc = s;
    end
    e.res = acc;
    e.ovf = ov;
    e.lat = (n == 0) ? 2 : n + D + 2;
    sb.push_back(e);
    got = 0;
    rd_cnt = 0;
    ecyc = prestarted ? 1 : 0;
    if (prestarted) begin
      drive_start(0);
    end else begin
      @(posedge clk); #1;
      drive_start(1);
      len = 8'(n);
      en = 1'b1;
    end
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (en) begin
        if (rd_en_s) begin
          check({tag, " rdAddr"}, 64'(rd_addr_s), 64'(rd_cnt));
          check({tag, " rdEn cycle"}, 64'(ecyc), 64'(rd_cnt + 1));
          rd_cnt++;
        end
        if (out_rdy_s) begin
          got = 1;
          check({tag, " scoreboard depth"}, 64'(sb.size()), 64'(1));
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " RES"}, res_s, e.res);
            check({tag, " ovf"}, 64'(ovf_s), 64'(e.ovf));
            check({tag, " latency"}, 64'(ecyc), 64'(e.lat));
            check({tag, " busy at outReady"}, 64'(busy_s), 64'(0));
          end
        end
      end else begin
        check({tag, " rdEn while disabled"}, 64'(rd_en_s), 64'(0));
        check({tag, " outReady while disabled"}, 64'(out_rdy_s), 64'(0));
      end
      @(posedge clk); #1;
      if (en) ecyc++;
      if (!hold) drive_start(0);
      en = toggle_en ? ~en : 1'b1;
    end
    check({tag, " result seen"}, 64'(got), 64'(1));
    check({tag, " read count"}, 64'(rd_cnt), 64'(n));
    en = 1'b1;
  endtask

  initial begin
    bit found;
    sel = 0;
    rst = 1'b1;
    en = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(busy0), 64'(0));
    check("reset rdEn", 64'(rdEn0), 64'(0));
    check("reset rdAddr", 64'(rdAddr0), 64'(0));
    check("reset outReady", 64'(outReady0), 64'(0));
    check("reset RES", 64'(RES0), 64'(0));
    check("reset ovf", 64'(ovf0), 64'(0));
    check("reset RES 20b", 64'(RES1), 64'(0));

    mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3;
    mem_b[0] = 4; mem_b[1] = 5; mem_b[2] = 6;
    run_job(3, 0, 0, 0, "basic");
    run_job(0, 0, 0, 0, "len0");

    sel = 1;
    for (int i = 0; i < 20; i++) begin
      mem_a[i] = -512;
      mem_b[i] = -512;
    end
    run_job(20, 0, 0, 0, "wrap");
    mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3;
    mem_b[0] = 4; mem_b[1] = 5; mem_b[2] = 6;
    run_job(3, 0, 0, 0, "ovf cleared");
    sel = 0;

    mem_a[0] = 100;  mem_a[1] = -200; mem_a[2] = 300; mem_a[3] = -400;
    mem_b[0] = -511; mem_b[1] = 511;  mem_b[2] = 7;   mem_b[3] = -3;
    run_job(4, 0, 0, 0, "free run");
    run_job(4, 1, 0, 0, "toggled enable");

    @(posedge clk); #1;
    drive_start(1);
    len = 8'd5;
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (rdEn0 && rdAddr0 == 8'd2) begin
        found = 1;
        rst = 1'b1;
      end else begin
        @(posedge clk); #1;
        drive_start(0);
      end
    end
    check("mid-job reset reached rdAddr 2", 64'(found), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    drive_start(0);
    @(negedge clk);
    check("post-reset busy", 64'(busy0), 64'(0));
    check("post-reset RES", 64'(RES0), 64'(0));
    check("post-reset rdEn", 64'(rdEn0), 64'(0));
    check("post-reset rdAddr", 64'(rdAddr0), 64'(0));
    check("post-reset outReady", 64'(outReady0), 64'(0));
    check("post-reset ovf", 64'(ovf0), 64'(0));

    mem_a[0] = -512; mem_a[1] = 511;
    mem_b[0] = -512; mem_b[1] = -512;
    run_job(2, 0, 0, 0, "fresh after reset");

    for (int i = 0; i < 5; i++) begin
      mem_a[i] = int'($urandom_range(0, 1023)) - 512;
      mem_b[i] = int'($urandom_range(0, 1023)) - 512;
    end
    run_job(5, 0, 1, 0, "held start job1");
    run_job(5, 0, 0, 1, "held start job2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
